// File: rtl/mac_datapath_pkg.sv
// Shared types for the MAC accelerator: controller-to-engine control word,
// engine status flags and the engine state encoding.
package mac_package;

  localparam int MAC_CNT_LEN = 1024;
  localparam int CNT_W       = $clog2(MAC_CNT_LEN) + 1;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic             clear;
    logic             enable;
    logic             simple_mul;
    logic             start;
    logic [4:0]       shift;
    logic [CNT_W-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             acc_valid;
  } flags_engine_t;

  typedef enum logic {
    ENG_IDLE,
    ENG_RUN
  } state_engine_t;

endpackage

// File: rtl/mac_datapath_mult_stage.sv
// Joins the A and B streams into a registered 64-bit signed product.
// The product register holds one beat until stage 2 signals consume.
module mac_mult_stage
  import mac_package::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                enable_i,
  input  logic                issue_en_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [DATA_W-1:0]   b_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic                prod_consume_i,
  output logic [2*DATA_W-1:0] prod_o,
  output logic                prod_valid_o
);

  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] a_ext, b_ext;
  logic                prod_valid_q, prod_valid_d;
  logic                ab_fire;

  // A new pair may enter only if the product slot is empty or being drained.
  always_comb begin
    a_ext        = {{DATA_W{a_data_i[DATA_W-1]}}, a_data_i};
    b_ext        = {{DATA_W{b_data_i[DATA_W-1]}}, b_data_i};
    ab_fire      = !clr_i && enable_i && issue_en_i && a_valid_i && b_valid_i &&
                   (!prod_valid_q || prod_consume_i);
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;
    if (clr_i) begin
      prod_d       = '0;
      prod_valid_d = 1'b0;
    end else if (ab_fire) begin
      prod_d       = a_ext * b_ext;
      prod_valid_d = 1'b1;
    end else if (prod_consume_i) begin
      prod_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
    end
  end

  assign a_ready_o    = ab_fire;
  assign b_ready_o    = ab_fire;
  assign prod_o       = prod_q;
  assign prod_valid_o = prod_valid_q;

endmodule

// File: rtl/mac_datapath.sv
// Streaming MAC engine: scalar product of len pairs (plus C, shifted) or
// len element-wise (a*b >>> shift) + c results.
module mac_datapath
  import mac_package::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [DATA_W-1:0]   b_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [DATA_W-1:0]   c_data_i,
  input  logic                c_valid_i,
  output logic                c_ready_o,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  output logic [DATA_W/8-1:0] d_strb_o,
  input  ctrl_engine_t        ctrl_i,
  output flags_engine_t       flags_o
);

  state_engine_t       state_q, state_d;
  logic                simple_q, simple_d;
  logic [4:0]          shift_q, shift_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   d_data_q, d_data_d;

  logic                clr, en, run, issue_en, final_beat, d_free, need_d;
  logic                prod_consume, prod_valid, ab_fire;
  logic [2*DATA_W-1:0] prod, c_ext;
  logic signed [2*DATA_W-1:0] acc_sum, acc_shift, mul_shift;

  mac_mult_stage u_mult (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr),
    .enable_i       (en),
    .issue_en_i     (issue_en),
    .a_data_i       (a_data_i),
    .a_valid_i      (a_valid_i),
    .a_ready_o      (ab_fire),
    .b_data_i       (b_data_i),
    .b_valid_i      (b_valid_i),
    .b_ready_o      (b_ready_o),
    .prod_consume_i (prod_consume),
    .prod_o         (prod),
    .prod_valid_o   (prod_valid)
  );

  // Stage 2 needs C and a free d slot only for beats that produce output.
  always_comb begin
    clr          = clear_i || ctrl_i.clear;
    en           = ctrl_i.enable;
    run          = (state_q == ENG_RUN);
    issue_en     = run && (issued_q < len_q);
    final_beat   = (cnt_q == len_q - CNT_W'(1));
    d_free       = !d_valid_q || d_ready_i;
    need_d       = simple_q || final_beat;
    prod_consume = run && en && prod_valid && (!need_d || (c_valid_i && d_free));
    c_ready_o    = !clr && prod_consume && need_d;
    c_ext        = {{DATA_W{c_data_i[DATA_W-1]}}, c_data_i};
    acc_sum      = acc_q + prod + c_ext;
    acc_shift    = acc_sum >>> shift_q;
    mul_shift    = $signed(prod) >>> shift_q;
  end

  always_comb begin
    state_d   = state_q;
    simple_d  = simple_q;
    shift_d   = shift_q;
    len_d     = len_q;
    issued_d  = issued_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;
    if (clr) begin
      state_d   = ENG_IDLE;
      simple_d  = 1'b0;
      shift_d   = '0;
      len_d     = '0;
      issued_d  = '0;
      cnt_d     = '0;
      acc_d     = '0;
      d_valid_d = 1'b0;
      d_data_d  = '0;
    end else if (en) begin
      if (d_valid_q && d_ready_i) begin
        d_valid_d = 1'b0;
      end
      if (state_q == ENG_IDLE && ctrl_i.start) begin
        simple_d = ctrl_i.simple_mul;
        shift_d  = ctrl_i.shift;
        len_d    = ctrl_i.len;
        issued_d = '0;
        cnt_d    = '0;
        acc_d    = '0;
        if (ctrl_i.len != '0) begin
          state_d = ENG_RUN;
        end
      end
      if (ab_fire) begin
        issued_d = issued_q + CNT_W'(1);
      end
      if (prod_consume) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (simple_q) begin
          d_valid_d = 1'b1;
          d_data_d  = mul_shift[DATA_W-1:0] + c_data_i;
          if (cnt_q + CNT_W'(1) == len_q) begin
            state_d = ENG_IDLE;
          end
        end else if (final_beat) begin
          d_valid_d = 1'b1;
          d_data_d  = acc_shift[DATA_W-1:0];
          acc_d     = '0;
          state_d   = ENG_IDLE;
        end else begin
          acc_d = acc_q + prod;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ENG_IDLE;
      simple_q  <= 1'b0;
      shift_q   <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      simple_q  <= simple_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
    end
  end

  assign a_ready_o         = ab_fire;
  assign d_valid_o         = d_valid_q;
  assign d_data_o          = d_data_q;
  assign d_strb_o          = '1;
  assign flags_o.cnt       = cnt_q;
  assign flags_o.acc_valid = d_valid_q && !simple_q;

endmodule

// File: tb/tb_mac_datapath.sv
// Randomized scoreboard bench for mac_datapath: stimulus pushes expected d
// beats from an arithmetic model; a negedge monitor pops and compares them.
module tb_mac_datapath;
  import mac_package::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clear_i;
  logic [31:0]   a_data_i, b_data_i, c_data_i;
  logic          a_valid_i, b_valid_i, c_valid_i;
  logic          a_ready_o, b_ready_o, c_ready_o;
  logic [31:0]   d_data_o;
  logic          d_valid_o;
  logic          d_ready_i;
  logic [3:0]    d_strb_o;
  ctrl_engine_t  ctrl_i;
  flags_engine_t flags_o;

  mac_datapath dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .a_data_i  (a_data_i),
    .a_valid_i (a_valid_i),
    .a_ready_o (a_ready_o),
    .b_data_i  (b_data_i),
    .b_valid_i (b_valid_i),
    .b_ready_o (b_ready_o),
    .c_data_i  (c_data_i),
    .c_valid_i (c_valid_i),
    .c_ready_o (c_ready_o),
    .d_data_o  (d_data_o),
    .d_valid_o (d_valid_o),
    .d_ready_i (d_ready_i),
    .d_strb_o  (d_strb_o),
    .ctrl_i    (ctrl_i),
    .flags_o   (flags_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int a;
    int b;
  } pair_t;

  typedef struct {
    int   data;
    logic acc_valid;
  } exp_t;

  pair_t ab_q[$];
  int    c_q[$];
  exp_t  exp_q[$];
  int    a_list[$], b_list[$], c_list[$];

  int    checks = 0, failures = 0;
  int    d_beats = 0, c_beats = 0, ab_beats = 0;
  int    ab0, c0;
  int    stall_ready_cnt = 0;
  bit    ab_fire = 0, c_fire = 0;
  bit    rand_bp = 0, force_stall = 0, any_ready_seen = 0, prev_stalled = 0;
  logic [31:0] prev_data = '0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic waitNeg();
    @(negedge clk_i);
    #1;
  endtask

  task automatic flushQueues();
    ab_q.delete();
    c_q.delete();
    exp_q.delete();
  endtask

  // A/B and C sources: pop on a sampled handshake, then present the next item.
  always @(posedge clk_i) begin
    #1;
    if (ab_fire && ab_q.size() > 0) ab_q.delete(0);
    if (ab_q.size() > 0 && (a_valid_i || $urandom_range(0, 3) != 0)) begin
      a_data_i  = ab_q[0].a;
      b_data_i  = ab_q[0].b;
      a_valid_i = 1'b1;
      b_valid_i = 1'b1;
    end else begin
      a_valid_i = 1'b0;
      b_valid_i = 1'b0;
    end
    if (c_fire && c_q.size() > 0) c_q.delete(0);
    if (c_q.size() > 0 && (c_valid_i || $urandom_range(0, 3) != 0)) begin
      c_data_i  = c_q[0];
      c_valid_i = 1'b1;
    end else begin
      c_valid_i = 1'b0;
    end
    d_ready_i = force_stall ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // Monitor: handshake sampling, hold checks and scoreboard comparison.
  always @(negedge clk_i) begin
    ab_fire = a_valid_i && a_ready_o;
    c_fire  = c_valid_i && c_ready_o;
    if (ab_fire) ab_beats++;
    if (c_fire) c_beats++;
    if (a_ready_o) any_ready_seen = 1;
    if (d_valid_o && !d_ready_i && a_ready_o) stall_ready_cnt++;
    if (prev_stalled && !rst_i) begin
      checkOutput("d_hold_valid", d_valid_o, 1);
      checkOutput("d_hold_data", d_data_o, prev_data);
    end
    prev_stalled = d_valid_o && !d_ready_i && !rst_i;
    prev_data    = d_data_o;
    if (d_valid_o && d_ready_i) begin
      d_beats++;
      if (exp_q.size() == 0) begin
        checkOutput("d_unexpected_beat", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("d_data", int'(d_data_o), e.data);
        checkOutput("acc_valid", flags_o.acc_valid, e.acc_valid);
      end
    end
  end

  // Model: plain 64-bit arithmetic over the staged a/b/c lists.
  task automatic applyStimulus(input bit simple, input int shift, input int len);
    longint s;
    exp_t   e;
    @(posedge clk_i);
    #1;
    s = 0;
    for (int i = 0; i < len; i++) begin
      longint p;
      pair_t  pr;
      p = longint'(a_list[i]) * longint'(b_list[i]);
      pr.a = a_list[i];
      pr.b = b_list[i];
      ab_q.push_back(pr);
      if (simple) begin
        e.data      = int'(p >>> shift) + c_list[i];
        e.acc_valid = 1'b0;
        exp_q.push_back(e);
        c_q.push_back(c_list[i]);
      end else begin
        s = s + p;
      end
    end
    if (!simple && len > 0) begin
      s           = s + longint'(c_list[0]);
      e.data      = int'(s >>> shift);
      e.acc_valid = 1'b1;
      exp_q.push_back(e);
      c_q.push_back(c_list[0]);
    end
    ab0 = ab_beats;
    c0  = c_beats;
    ctrl_i.simple_mul = simple;
    ctrl_i.shift      = 5'(shift);
    ctrl_i.len        = CNT_W'(len);
    ctrl_i.start      = 1'b1;
    @(posedge clk_i);
    #1;
    ctrl_i.start = 1'b0;
  endtask

  task automatic waitDone(input bit simple, input int len);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      waitNeg();
      n++;
    end
    checkOutput("done_timeout", exp_q.size(), 0);
    waitNeg();
    waitNeg();
    checkOutput("cnt", flags_o.cnt, len);
    checkOutput("c_beats", c_beats - c0, simple ? len : 1);
    checkOutput("ab_beats", ab_beats - ab0, len);
    checkOutput("a_ready_idle", a_ready_o, 0);
    flushQueues();
  endtask

  task automatic randomLists(input int len);
    a_list.delete();
    b_list.delete();
    c_list.delete();
    for (int i = 0; i < len; i++) begin
      a_list.push_back(int'($urandom));
      b_list.push_back(int'($urandom));
      c_list.push_back(int'($urandom));
    end
  endtask

  task automatic disturbRun(input bit use_reset);
    int n = 0;
    randomLists(5);
    applyStimulus(0, 3, 5);
    while (ab_beats - ab0 < 2 && n < 100) begin
      waitNeg();
      n++;
    end
    checkOutput("disturb_wait", ab_beats - ab0 >= 2, 1);
    @(posedge clk_i);
    if (use_reset) begin
      #3;
      rst_i = 1'b1;
      #1;
      checkOutput("rst_async_cnt", flags_o.cnt, 0);
      checkOutput("rst_async_d_valid", d_valid_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
    end else begin
      #1;
      clear_i = 1'b1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0;
    end
    flushQueues();
    waitNeg();
    checkOutput("disturb_d_valid", d_valid_o, 0);
    checkOutput("disturb_cnt", flags_o.cnt, 0);
    checkOutput("disturb_a_ready", a_ready_o, 0);
    repeat (3) waitNeg();
    randomLists(5);
    applyStimulus(0, 2, 5);
    waitDone(0, 5);
  endtask

  initial begin
    int d0, n;
    rst_i     = 1'b1;
    clear_i   = 1'b0;
    a_data_i  = '0;
    b_data_i  = '0;
    c_data_i  = '0;
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    c_valid_i = 1'b0;
    d_ready_i = 1'b1;
    ctrl_i    = '0;
    ctrl_i.enable = 1'b1;
    repeat (3) waitNeg();
    checkOutput("rst_a_ready", a_ready_o, 0);
    checkOutput("rst_c_ready", c_ready_o, 0);
    checkOutput("rst_d_valid", d_valid_o, 0);
    checkOutput("rst_d_data", d_data_o, 0);
    checkOutput("rst_strb", d_strb_o, 15);
    checkOutput("rst_cnt", flags_o.cnt, 0);
    checkOutput("rst_acc_valid", flags_o.acc_valid, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (2) waitNeg();

    $display("[TB] simple mode directed");
    a_list = '{2, -3, 4};
    b_list = '{5, 6, 7};
    c_list = '{1, 1, 1};
    applyStimulus(1, 0, 3);
    waitDone(1, 3);

    $display("[TB] accumulate mode directed");
    a_list = '{1, 2, 3, 4};
    b_list = '{10, 10, 10, 10};
    c_list = '{5};
    applyStimulus(0, 1, 4);
    waitDone(0, 4);

    a_list = '{-8, -8};
    b_list = '{1, 1};
    c_list = '{0};
    applyStimulus(0, 2, 2);
    waitDone(0, 2);

    $display("[TB] backpressure");
    a_list = '{7, -9, 100000, -1};
    b_list = '{3, 11, 70000, -1};
    c_list = '{4, -5, 6, 0};
    d0 = d_beats;
    applyStimulus(1, 0, 4);
    n = 0;
    while (d_beats == d0 && n < 100) begin
      waitNeg();
      n++;
    end
    checkOutput("bp_first_beat", d_beats - d0, 1);
    force_stall     = 1'b1;
    stall_ready_cnt = 0;
    repeat (10) waitNeg();
    force_stall = 1'b0;
    checkOutput("bp_ab_ready_drop", stall_ready_cnt <= 1, 1);
    waitDone(1, 4);

    $display("[TB] len zero");
    repeat (2) waitNeg();
    d0 = d_beats;
    a_list.delete();
    b_list.delete();
    c_list.delete();
    any_ready_seen = 0;
    applyStimulus(1, 0, 0);
    ab_q.push_back('{3, 4});
    c_q.push_back(1);
    repeat (10) waitNeg();
    checkOutput("len0_ready", any_ready_seen, 0);
    checkOutput("len0_d_beats", d_beats - d0, 0);
    checkOutput("len0_cnt", flags_o.cnt, 0);
    flushQueues();
    repeat (2) waitNeg();

    $display("[TB] mid-run clear and reset");
    disturbRun(0);
    disturbRun(1);

    $display("[TB] randomized operations");
    rand_bp = 1'b1;
    for (int t = 0; t < 12; t++) begin
      bit sm;
      int ln;
      sm = 1'($urandom_range(0, 1));
      ln = $urandom_range(1, 8);
      randomLists(ln);
      applyStimulus(sm, $urandom_range(0, 31), ln);
      waitDone(sm, ln);
    end
    rand_bp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_datapath.md
# mac_datapath

Streaming multiply-accumulate datapath of the MAC accelerator. It sits downstream of the streamer's a/b/c sources and upstream of its d sink. It is driven by the controller FSM through `ctrl_engine_t` and reports progress through `flags_engine_t`. It runs either one scalar product of `len` element pairs or `len` independent element-wise multiply-adds.

## Interface
Parameters:
- `DATA_W`, default 32: stream data width; fixed by the streamer, not overridable.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clear_i`  in  1  synchronous soft clear, active-high.
- `a_i`  in (hwpe_stream sink)  32  signed operand A stream.
- `b_i`  in (hwpe_stream sink)  32  signed operand B stream.
- `c_i`  in (hwpe_stream sink)  32  signed offset C stream.
- `d_o`  out (hwpe_stream source)  32  result stream.
- `ctrl_i`  in  `ctrl_engine_t`  clear/enable/simple_mul/start/shift(5b)/len(11b).
- `flags_o`  out  `flags_engine_t`  cnt(11b), acc_valid.

## Operation
- States: `ENG_IDLE`, `ENG_RUN`.
- `ctrl_i.start` in IDLE:
  - latches simple_mul, shift and len;
  - zeroes acc, issue count and cnt;
  - moves to RUN.
- start in RUN is ignored.
- start with len=0 stays in IDLE, emits nothing and leaves cnt at 0.
- `ctrl_i.enable`=0 freezes all registers and forces every ready low; d valid/data already presented are held.
- Stage 1 (multiply):
  - a and b are joined; both handshake together.
  - `a.ready = b.ready = RUN & enable & a.valid & b.valid & issued<len & (!prod_valid | prod_consume)`.
  - On the handshake, prod_q = signed(a)×signed(b), 64 bits; `issued` increments.
- Stage 2, accumulate mode (simple_mul=0):
  - A non-final product is consumed unconditionally: acc += prod_q (64 bits, wraps mod 2^64), cnt++.
  - The final product (cnt==len-1) is consumed only when c.valid and the d slot is free.
  - On that final consume, c is consumed and d = ((acc+prod_q+sext(c)) >>> shift)[31:0].
  - Then acc clears and the block returns to IDLE.
- Stage 2, simple mode (simple_mul=1):
  - Each product is consumed only when c.valid and the d slot is free.
  - d = ((prod_q >>> shift)[31:0] + c) mod 2^32; cnt++.
  - After the len-th beat the block returns to IDLE.
- d slot is free when `!d.valid | d.ready`. d.valid stays high, with data stable, until the d handshake.
- flags: cnt = products consumed since start; acc_valid = d.valid & !simple_mul.
- clear_i or ctrl_i.clear has highest priority over everything. It resets to the reset state on the next edge, including dropping d.valid and discarding in-flight data.
- Reset values: state IDLE, all readys 0, d.valid 0, d.data 0, strb all-ones, cnt 0, acc_valid 0, acc/prod 0.

## Timing
- Throughput: one pair per cycle when d.ready is held high.
- Latency: a/b handshake at cycle N → d.valid at N+2 in simple mode. In accumulate mode, last pair at N → d.valid at N+2.
- Backpressure:
  - d.ready low stalls stage 2 at the first product that needs the d slot.
  - stage 1 then takes at most one further pair, so a/b ready drop within one cycle.
- A start pulse coincident with the block going back to IDLE is ignored. The FSM must pulse start at least one cycle after d handshakes.
- Reset asserted mid-run clears immediately (asynchronously); no partial beat appears after release.

## Structure
- `mac_package` gains `state_engine_t {ENG_IDLE, ENG_RUN}`.
- `ctrl_engine_t`, `flags_engine_t` and `MAC_CNT_LEN` stay in `mac_package` as they are.
- One sub-module is natural: `mac_mult_stage`, which joins a/b into the registered 64-bit product with a valid/consume handshake.
- The counters, accumulator, C join and d output register live in `mac_datapath`.

## Test plan
- Simple mode, shift=0, len=3: a={2,-3,4}, b={5,6,7}, c={1,1,1} → d={11,-17,29}, cnt=3, acc_valid never high.
- Accumulate mode, len=4: a={1,2,3,4}, b=10 each, c=5, shift=1 → single d=52, acc_valid high with it; exactly one c consumed.
- Accumulate mode, negative result: len=2, a={-8,-8}, b={1,1}, c=0, shift=2 → d=-4 (0xFFFFFFFC).
- Backpressure: simple mode, len=4, d.ready low for 10 cycles after the first beat → a.ready low within 1 cycle; all 4 results correct and in order; d data stable while stalled.
- len=0 start → block stays in IDLE, no ready asserted, no d beat, cnt=0.
- Mid-run disturbance: clear pulse after 2 of 5 accumulate pairs → IDLE, d.valid 0, cnt 0; a fresh start then yields the correct result. Repeat with rst_i asserted mid-run instead of clear.
